// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the requester-side and memory-side signals of the round-robin
//   memory arbiter.
//
//   modport master : the arbiter's view. It receives requests and slave
//                    answers, and it drives grants, completions and the
//                    memory request.
//   modport slave  : the environment's view, which is the requesters plus the
//                    memory slave.
//
//   Requester side : req_valid/req_instr/req_addr/req_wdata/req_wstrb (packed,
//                    requester i at [W*i +: W]), req_ready, req_rdata,
//                    req_err, gnt
//   Memory side    : mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb,
//                    mem_ready, mem_rdata
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_instr;
    logic [32*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_wdata;
    logic [4*NREQ-1:0]  req_wstrb;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        req_rdata;
    logic               req_err;
    logic [NREQ-1:0]    gnt;

    logic               mem_valid;
    logic               mem_instr;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wstrb;
    logic               mem_ready;
    logic [31:0]        mem_rdata;

    modport master (
        input  req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        output req_ready, req_rdata, req_err, gnt,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output req_valid, req_instr, req_addr, req_wdata, req_wstrb,
        input  req_ready, req_rdata, req_err, gnt,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter that shares one picorv32-style native memory port
//   among NREQ requesters. The winning request is latched into registered
//   mem_* outputs and held there until the slave answers. Read data and a
//   one-cycle ready pulse are then returned to the winner. A watchdog ends
//   any transfer that the slave never acknowledges and flags it with req_err.
//
//   Parameters
//     NREQ    : number of requesters (2..8)
//     TIMEOUT : maximum number of cycles mem_valid waits for mem_ready
//               (0 disables the watchdog)
//   Ports
//     clk     : rising-edge clock
//     resetn  : asynchronous, active-low reset
//     bus     : mem_arbiter_if.master (requester and memory signals)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.master bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [LW-1:0] last;
    logic [CW-1:0] wd_cnt;

    logic [31:0] addr_arr  [NREQ];
    logic [31:0] wdata_arr [NREQ];
    logic [3:0]  wstrb_arr [NREQ];

    logic          pick_valid;
    logic [LW-1:0] pick_idx;
    logic [LW-1:0] cand;
    logic          timed_out;

    // Split the packed request buses into per-requester arrays so that the
    // winner can be indexed directly.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = bus.req_addr[32*i +: 32];
        assign wdata_arr[i] = bus.req_wdata[32*i +: 32];
        assign wstrb_arr[i] = bus.req_wstrb[4*i +: 4];
    end

    // Round-robin search that starts just above the last winner and wraps.
    // The loop walks from the farthest candidate down to the nearest one, so
    // the nearest requesting candidate is the one that remains selected.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = LW'((int'(last) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT - 1));

    // Main controller. Every output is a register. Once a request is granted,
    // the mem_* registers hold their values until the transfer ends, and any
    // later change on the request inputs is ignored. A mem_ready that arrives
    // on the watchdog's final cycle takes precedence over the timeout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            last          <= LW'(NREQ - 1);
            wd_cnt        <= '0;
            bus.gnt       <= '0;
            bus.req_ready <= '0;
            bus.req_rdata <= '0;
            bus.req_err   <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_instr <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        bus.gnt       <= NREQ'(1) << pick_idx;
                        last          <= pick_idx;
                        bus.mem_valid <= 1'b1;
                        bus.mem_instr <= bus.req_instr[pick_idx];
                        bus.mem_addr  <= addr_arr[pick_idx];
                        bus.mem_wdata <= wdata_arr[pick_idx];
                        bus.mem_wstrb <= wstrb_arr[pick_idx];
                        wd_cnt        <= '0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.req_rdata <= bus.mem_rdata;
                        bus.req_err   <= 1'b0;
                        bus.req_ready <= bus.gnt;
                        bus.mem_valid <= 1'b0;
                        state         <= DONE;
                    end else if (timed_out) begin
                        bus.req_rdata <= '0;
                        bus.req_err   <= 1'b1;
                        bus.req_ready <= bus.gnt;
                        bus.mem_valid <= 1'b0;
                        state         <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                DONE: begin
                    bus.req_ready <= '0;
                    bus.gnt       <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
